// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe: linear ROM addressing, sync/blank delay matched to ROM
// latency, and registered grayscale RGB with overrun detection.
module vga_pixel_pipe #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int ADDR_W      = 19,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk_25,
  input  logic              n_rst,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              video_on_in,
  input  logic              synch_in,
  input  logic [7:0]        pixel_data,
  output logic [ADDR_W-1:0] address,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic              vga_sync_n,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              frame_err
);

  localparam int DEPTH = MEM_LATENCY + 1;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  logic [ADDR_W-1:0] pix_idx;
  logic              wrapped;
  logic              armed;
  logic [DEPTH-1:0]  hs_d;
  logic [DEPTH-1:0]  vs_d;
  logic [DEPTH-1:0]  vo_d;
  logic [DEPTH-1:0]  sy_d;
  logic [7:0]        pix_q;
  logic              at_last;

  assign at_last = (pix_idx == LAST);

  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      pix_idx <= '0;
    end else if (!vsync_in) begin
      pix_idx <= '0;
    end else if (video_on_in) begin
      pix_idx <= at_last ? '0 : pix_idx + ADDR_W'(1);
    end
  end

  // armed keeps a frame entered mid-way after reset from flagging.
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      wrapped   <= 1'b0;
      armed     <= 1'b0;
      frame_err <= 1'b0;
    end else if (!vsync_in) begin
      wrapped <= 1'b0;
      armed   <= 1'b1;
    end else if (video_on_in) begin
      if (wrapped && armed)
        frame_err <= 1'b1;
      wrapped <= at_last;
    end
  end

  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      hs_d <= '1;
      vs_d <= '1;
      sy_d <= '1;
      vo_d <= '0;
    end else begin
      hs_d <= {hs_d[DEPTH-2:0], hsync_in};
      vs_d <= {vs_d[DEPTH-2:0], vsync_in};
      sy_d <= {sy_d[DEPTH-2:0], synch_in};
      vo_d <= {vo_d[DEPTH-2:0], video_on_in};
    end
  end

  // vo_d[MEM_LATENCY-1] lines up with the ROM q for that pixel.
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst)
      pix_q <= '0;
    else if (vo_d[MEM_LATENCY-1])
      pix_q <= pixel_data;
    else
      pix_q <= '0;
  end

  assign address     = pix_idx;
  assign vga_hs      = hs_d[DEPTH-1];
  assign vga_vs      = vs_d[DEPTH-1];
  assign vga_sync_n  = sy_d[DEPTH-1];
  assign vga_blank_n = vo_d[DEPTH-1];
  assign vga_r       = pix_q;
  assign vga_g       = pix_q;
  assign vga_b       = pix_q;

endmodule
